gpio_bank: RTL and testbench



---
 rtl/gpio_bank_if.sv | 16 +
 rtl/gpio_bank.sv | 166 ++++++++++++++++
 tb/tb_gpio_bank.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_bank_if.sv
// j1a I/O bus as seen by one peripheral bank: select, strobes, register
// index, write data from the CPU and combinational read data back to it.
interface gpio_bank_if;
    logic        cs;
    logic        io_wr;
    logic        io_rd;
    logic [3:0]  reg_sel;
    logic [15:0] dout;
    logic [15:0] din;

    // CPU side drives the request and samples din; the bank does the reverse.
    modport master (output cs, output io_wr, output io_rd, output reg_sel,
                    output dout, input din);
    modport slave  (input cs, input io_wr, input io_rd, input reg_sel,
                    input dout, output din);
endinterface

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: OUT/DIR registers with set/clear/toggle writes, a
// 2-flop input synchroniser, optional per-channel debounce, edge capture, level irq.
module gpio_bank #(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             resetq,
    gpio_bank_if.slave       bus,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);

    localparam logic [3:0] R_OUT     = 4'd0;
    localparam logic [3:0] R_DIR     = 4'd1;
    localparam logic [3:0] R_IN      = 4'd2;
    localparam logic [3:0] R_SET     = 4'd3;
    localparam logic [3:0] R_CLR     = 4'd4;
    localparam logic [3:0] R_TGL     = 4'd5;
    localparam logic [3:0] R_RISE_EN = 4'd6;
    localparam logic [3:0] R_FALL_EN = 4'd7;
    localparam logic [3:0] R_EVENT   = 4'd8;
    localparam logic [3:0] R_PINOUT  = 4'd9;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] event_q, event_d;
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] rd_val;

    // io_rd carries no side effects and dout may be wider than the bank.
    logic unused_bus;
    assign unused_bus = ^{bus.io_rd, bus.dout};

    assign wr_en = bus.cs & bus.io_wr;
    assign wdata = bus.dout[WIDTH-1:0];

    // Register file writes, including the atomic read-modify-write aliases.
    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        if (wr_en) begin
            case (bus.reg_sel)
                R_OUT:     out_d     = wdata;
                R_DIR:     dir_d     = wdata;
                R_SET:     out_d     = out_q | wdata;
                R_CLR:     out_d     = out_q & ~wdata;
                R_TGL:     out_d     = out_q ^ wdata;
                R_RISE_EN: rise_en_d = wdata;
                R_FALL_EN: fall_en_d = wdata;
                default:   ;
            endcase
        end
    end

    // Input path and edge capture; a fresh edge beats a same-cycle W1C.
    always_comb begin
        s1_d    = pin_in;
        s2_d    = s1_q;
        prev_d  = filt_q;
        w1c     = (wr_en && bus.reg_sel == R_EVENT) ? wdata : '0;
        rise    = filt_q & ~prev_q & rise_en_q;
        fall    = ~filt_q & prev_q & fall_en_q;
        event_d = (event_q & ~w1c) | rise | fall;
        irq_d   = |event_q;
    end

    generate
        if (DEB_CYCLES == 0) begin : g_no_deb
            assign filt_d = s2_q;
        end else begin : g_deb
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q [WIDTH];
            logic [CNT_W-1:0] cnt_d [WIDTH];

            // A channel must disagree with filt for DEB_CYCLES straight cycles.
            always_comb begin
                filt_d = filt_q;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_d[i] = '0;
                    if (s2_q[i] != filt_q[i]) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            filt_d[i] = s2_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge resetq) begin
                if (!resetq) begin
                    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            event_q   <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            filt_q    <= '0;
            prev_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            event_q   <= event_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            filt_q    <= filt_d;
            prev_q    <= prev_d;
            irq_q     <= irq_d;
        end
    end

    // Zero-latency read mux; write-only aliases and unmapped slots read 0.
    always_comb begin
        rd_val = '0;
        case (bus.reg_sel)
            R_OUT:     rd_val = out_q;
            R_DIR:     rd_val = dir_q;
            R_IN:      rd_val = filt_q;
            R_RISE_EN: rd_val = rise_en_q;
            R_FALL_EN: rd_val = fall_en_q;
            R_EVENT:   rd_val = event_q;
            R_PINOUT:  rd_val = out_q & dir_q;
            default:   rd_val = '0;
        endcase
    end

    assign bus.din = bus.cs ? 16'(rd_val) : 16'h0000;
    assign pin_out = out_q;
    assign pin_oe  = dir_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank: an 8-bit undebounced bank and a 16-bit bank with a
// 4-cycle debounce, both checked every cycle against a behavioural model.
module tb_gpio_bank;
    logic clk;
    logic resetq;

    localparam int MW   [2] = '{8, 16};
    localparam int MDEB [2] = '{0, 4};

    logic        b_cs   [2];
    logic        b_wr   [2];
    logic [3:0]  b_sel  [2];
    logic [15:0] b_dout [2];

    logic [7:0]  pin_in0, pin_out0, pin_oe0;
    logic [15:0] pin_in1, pin_out1, pin_oe1;
    logic        irq0, irq1;

    gpio_bank_if bus0 ();
    gpio_bank_if bus1 ();

    assign bus0.cs      = b_cs[0];
    assign bus0.io_wr   = b_wr[0];
    assign bus0.io_rd   = b_cs[0] & ~b_wr[0];
    assign bus0.reg_sel = b_sel[0];
    assign bus0.dout    = b_dout[0];
    assign bus1.cs      = b_cs[1];
    assign bus1.io_wr   = b_wr[1];
    assign bus1.io_rd   = b_cs[1] & ~b_wr[1];
    assign bus1.reg_sel = b_sel[1];
    assign bus1.dout    = b_dout[1];

    gpio_bank #(.WIDTH(8), .DEB_CYCLES(0), .CNT_W(8)) u_dut0 (
        .clk(clk), .resetq(resetq), .bus(bus0.slave),
        .pin_in(pin_in0), .pin_out(pin_out0), .pin_oe(pin_oe0), .irq(irq0)
    );

    gpio_bank #(.WIDTH(16), .DEB_CYCLES(4), .CNT_W(3)) u_dut1 (
        .clk(clk), .resetq(resetq), .bus(bus1.slave),
        .pin_in(pin_in1), .pin_out(pin_out1), .pin_oe(pin_oe1), .irq(irq1)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_on  = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: per-instance register image and per-channel input history
    logic [15:0] m_out [2], m_dir [2], m_rise [2], m_fall [2], m_ev [2];
    logic [15:0] m_s1 [2], m_s2 [2], m_filt [2], m_prev [2];
    logic        m_irq [2];
    int          m_run [2][16];

    function automatic logic [15:0] pins(input int k);
        return (k == 0) ? {8'h00, pin_in0} : pin_in1;
    endfunction

    function automatic logic [15:0] mask_of(input int k);
        return (MW[k] == 16) ? 16'hFFFF : ((16'h1 << MW[k]) - 16'h1);
    endfunction

    task automatic model_step(input int k);
        logic [15:0] msk, d, ev_n, filt_n;
        bit wr;
        msk  = mask_of(k);
        d    = b_dout[k] & msk;
        wr   = b_cs[k] & b_wr[k];
        ev_n = m_ev[k] & ~((wr && b_sel[k] == 4'd8) ? d : 16'h0);
        ev_n = ev_n | (m_filt[k] & ~m_prev[k] & m_rise[k]);
        ev_n = ev_n | (~m_filt[k] & m_prev[k] & m_fall[k]);
        m_irq[k] = (m_ev[k] != 16'h0);
        filt_n = m_filt[k];
        for (int i = 0; i < MW[k]; i++) begin
            if (MDEB[k] == 0) begin
                filt_n[i] = m_s2[k][i];
            end else if (m_s2[k][i] != m_filt[k][i]) begin
                m_run[k][i]++;
                if (m_run[k][i] == MDEB[k]) begin
                    filt_n[i]  = m_s2[k][i];
                    m_run[k][i] = 0;
                end
            end else begin
                m_run[k][i] = 0;
            end
        end
        m_prev[k] = m_filt[k];
        m_filt[k] = filt_n;
        m_s2[k]   = m_s1[k];
        m_s1[k]   = pins(k) & msk;
        m_ev[k]   = ev_n & msk;
        if (wr) begin
            case (b_sel[k])
                4'd0: m_out[k]  = d;
                4'd1: m_dir[k]  = d;
                4'd3: m_out[k]  = m_out[k] | d;
                4'd4: m_out[k]  = m_out[k] & ~d;
                4'd5: m_out[k]  = m_out[k] ^ d;
                4'd6: m_rise[k] = d;
                4'd7: m_fall[k] = d;
                default: ;
            endcase
        end
    endtask

    always @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            for (int k = 0; k < 2; k++) begin
                m_out[k] = 0; m_dir[k] = 0; m_rise[k] = 0; m_fall[k] = 0; m_ev[k] = 0;
                m_s1[k] = 0; m_s2[k] = 0; m_filt[k] = 0; m_prev[k] = 0; m_irq[k] = 0;
                for (int i = 0; i < 16; i++) m_run[k][i] = 0;
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    function automatic logic [15:0] exp_din(input int k);
        if (!b_cs[k]) return 16'h0;
        case (b_sel[k])
            4'd0: return m_out[k];
            4'd1: return m_dir[k];
            4'd2: return m_filt[k];
            4'd6: return m_rise[k];
            4'd7: return m_fall[k];
            4'd8: return m_ev[k];
            4'd9: return m_out[k] & m_dir[k];
            default: return 16'h0;
        endcase
    endfunction

    // scoreboard compare, once per cycle away from the active edge
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("pin_out0", {8'h00, pin_out0}, m_out[0]);
            chk("pin_oe0",  {8'h00, pin_oe0},  m_dir[0]);
            chk("irq0",     {15'h0, irq0},     {15'h0, m_irq[0]});
            chk("din0",     bus0.din,          exp_din(0));
            chk("pin_out1", pin_out1,          m_out[1]);
            chk("pin_oe1",  pin_oe1,           m_dir[1]);
            chk("irq1",     {15'h0, irq1},     {15'h0, m_irq[1]});
            chk("din1",     bus1.din,          exp_din(1));
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_wr(input int k, input logic [3:0] sel, input logic [15:0] d);
        tick();
        b_cs[k] = 1'b1; b_wr[k] = 1'b1; b_sel[k] = sel; b_dout[k] = d;
        tick();
        b_wr[k] = 1'b0;
    endtask

    function automatic logic [15:0] din_of(input int k);
        return (k == 0) ? bus0.din : bus1.din;
    endfunction

    task automatic rd_chk(input int k, input logic [3:0] sel, input logic [15:0] exp, input string name);
        b_cs[k] = 1'b1; b_wr[k] = 1'b0; b_sel[k] = sel;
        #1;
        chk(name, din_of(k), exp);
    endtask

    initial begin
        resetq = 1'b0;
        pin_in0 = 8'h00;
        pin_in1 = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            b_cs[k] = 0; b_wr[k] = 0; b_sel[k] = 0; b_dout[k] = 0;
        end
        ticks(3);
        cmp_on = 1'b1;
        chk("rst_pin_out1", pin_out1, 16'h0000);
        chk("rst_irq0", {15'h0, irq0}, 16'h0000);
        resetq = 1'b1;
        tick();

        // OUT/DIR and pad drive; upper dout bits are dropped on the 8-bit bank
        bus_wr(0, 4'd0, 16'hFFA5);
        bus_wr(0, 4'd1, 16'h000F);
        chk("pin_out_a5", {8'h00, pin_out0}, 16'h00A5);
        chk("pin_oe_0f",  {8'h00, pin_oe0},  16'h000F);
        rd_chk(0, 4'd9, 16'h0005, "pinout_reg");
        rd_chk(0, 4'd0, 16'h00A5, "out_reg");

        bus_wr(0, 4'd3, 16'h0010);
        rd_chk(0, 4'd0, 16'h00B5, "set_10");
        bus_wr(0, 4'd4, 16'h0001);
        rd_chk(0, 4'd0, 16'h00B4, "clr_01");
        bus_wr(0, 4'd5, 16'h00FF);
        rd_chk(0, 4'd0, 16'h004B, "tgl_ff");
        rd_chk(0, 4'd3, 16'h0000, "rd_set");
        rd_chk(0, 4'd4, 16'h0000, "rd_clr");
        rd_chk(0, 4'd5, 16'h0000, "rd_tgl");
        rd_chk(0, 4'd12, 16'h0000, "rd_unmapped");

        // pin_in -> IN in 3 cycles, EVENT in 4, irq in 5; W1C clears
        bus_wr(0, 4'd6, 16'h0001);
        rd_chk(0, 4'd2, 16'h0000, "in_before");
        pin_in0[0] = 1'b1;
        ticks(2);
        chk("in_t2", {15'h0, bus0.din[0]}, 16'h0000);
        tick();
        chk("in_t3", {15'h0, bus0.din[0]}, 16'h0001);
        chk("irq_t3", {15'h0, irq0}, 16'h0000);
        tick();
        chk("irq_t4", {15'h0, irq0}, 16'h0000);
        rd_chk(0, 4'd8, 16'h0001, "event_t4");
        tick();
        chk("irq_t5", {15'h0, irq0}, 16'h0001);
        b_wr[0] = 1'b1; b_sel[0] = 4'd8; b_dout[0] = 16'h0001;
        tick();
        b_wr[0] = 1'b0;
        rd_chk(0, 4'd8, 16'h0000, "event_w1c");
        tick();
        chk("irq_w1c", {15'h0, irq0}, 16'h0000);

        // debounce: a 3-cycle pulse is rejected, a held level lands 4 cycles after s2
        b_cs[1] = 1'b1; b_sel[1] = 4'd2;
        pin_in1[2] = 1'b1;
        ticks(3);
        pin_in1[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("deb_pulse", {15'h0, bus1.din[2]}, 16'h0000);
        end
        pin_in1[2] = 1'b1;
        ticks(5);
        chk("deb_hold_e5", {15'h0, bus1.din[2]}, 16'h0000);
        tick();
        chk("deb_hold_e6", {15'h0, bus1.din[2]}, 16'h0001);
        pin_in1[2] = 1'b0;
        ticks(10);

        // a falling edge and a W1C of the same EVENT bit in one cycle: set wins
        pin_in1[7] = 1'b1;
        ticks(10);
        bus_wr(1, 4'd7, 16'h0080);
        pin_in1[7] = 1'b0;
        ticks(10);
        chk("fall_irq", {15'h0, irq1}, 16'h0001);
        rd_chk(1, 4'd8, 16'h0080, "fall_event");
        pin_in1[7] = 1'b1;
        ticks(10);
        pin_in1[7] = 1'b0;
        ticks(6);
        b_wr[1] = 1'b1; b_sel[1] = 4'd8; b_dout[1] = 16'h0080;
        tick();
        b_wr[1] = 1'b0;
        rd_chk(1, 4'd8, 16'h0080, "collide_event");
        chk("collide_irq", {15'h0, irq1}, 16'h0001);
        tick();
        chk("collide_irq2", {15'h0, irq1}, 16'h0001);

        // randomized traffic on both banks
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                b_cs[k]   = 1'($urandom_range(0, 1));
                b_wr[k]   = ($urandom_range(0, 3) == 0);
                b_sel[k]  = 4'($urandom_range(0, 15));
                b_dout[k] = 16'($urandom);
            end
            pin_in0 = pin_in0 ^ 8'($urandom & $urandom & $urandom);
            pin_in1 = pin_in1 ^ 16'($urandom & $urandom & $urandom & $urandom);
        end

        // reset mid-debounce with events pending on 0x8001
        tick();
        for (int k = 0; k < 2; k++) begin
            b_cs[k] = 1'b0; b_wr[k] = 1'b0;
        end
        pin_in1 = 16'h0000;
        ticks(12);
        bus_wr(1, 4'd8, 16'hFFFF);
        bus_wr(1, 4'd6, 16'h8001);
        pin_in1 = 16'h8001;
        ticks(12);
        rd_chk(1, 4'd8, 16'h8001, "pend_event");
        chk("pend_irq", {15'h0, irq1}, 16'h0001);
        pin_in1[3] = 1'b1;
        ticks(3);
        resetq = 1'b0;
        #1;
        chk("rst_din",  bus1.din, 16'h0000);
        chk("rst_irq1", {15'h0, irq1}, 16'h0000);
        chk("rst_oe1",  pin_oe1, 16'h0000);
        rd_chk(1, 4'd6, 16'h0000, "rst_rise_en");
        rd_chk(1, 4'd2, 16'h0000, "rst_in");
        ticks(2);
        resetq = 1'b1;
        ticks(10);
        rd_chk(1, 4'd8, 16'h0000, "post_rst_event");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
